// File: rtl/music_pkg.sv
// Shared types and constants for the music player control path.
package music_pkg;

    localparam int unsigned SONG_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_ADVANCE = 2'd2
    } state_t;

    localparam logic [1:0] RPT_OFF = 2'b00;
    localparam logic [1:0] RPT_ALL = 2'b01;
    localparam logic [1:0] RPT_ONE = 2'b10;

endpackage

// File: rtl/song_index_next.sv
// Candidate song indices for next / prev / song_done, with wrap and end-of-list flag.
module song_index_next
    import music_pkg::*;
#(
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned SONG_W    = SONG_W_DEFAULT
) (
    input  logic [SONG_W-1:0] song,
    input  logic [1:0]        repeat_mode,
    input  logic              in_window,
    output logic [SONG_W-1:0] next_idx_c,
    output logic [SONG_W-1:0] prev_idx_c,
    output logic [SONG_W-1:0] done_idx_c,
    output logic              done_eol_c
);

    localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

    logic is_last;

    always_comb begin
        is_last    = (song == LAST);
        next_idx_c = is_last ? '0 : song + SONG_W'(1);
        prev_idx_c = song;
        done_idx_c = next_idx_c;
        done_eol_c = 1'b0;

        // Outside the window prev restarts the current song
        if (in_window) begin
            prev_idx_c = (song == '0) ? LAST : song - SONG_W'(1);
        end

        case (repeat_mode)
            RPT_ONE: done_idx_c = song;
            RPT_ALL: done_idx_c = next_idx_c;
            default: done_eol_c = is_last;
        endcase
    end

endmodule

// File: rtl/playlist_mcu.sv
// Master control unit: play/pause FSM, playlist sequencing, repeat modes and prev window.
module playlist_mcu
    import music_pkg::*;
#(
    parameter int unsigned NUM_SONGS   = 4,
    parameter int unsigned SONG_W      = SONG_W_DEFAULT,
    parameter int unsigned PREV_WINDOW = 96,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic [1:0]        repeat_mode,
    input  logic              beat,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song,
    output logic              playlist_done
);

    state_t             state, state_nxt;
    logic               resume, resume_nxt;
    logic [SONG_W-1:0]  song_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               done_nxt;
    logic               in_window;

    logic [SONG_W-1:0]  next_idx, prev_idx, done_idx;
    logic               done_eol;

    assign in_window = (beat_cnt < CNT_W'(PREV_WINDOW));

    song_index_next #(
        .NUM_SONGS (NUM_SONGS),
        .SONG_W    (SONG_W)
    ) u_song_index_next (
        .song        (song),
        .repeat_mode (repeat_mode),
        .in_window   (in_window),
        .next_idx_c  (next_idx),
        .prev_idx_c  (prev_idx),
        .done_idx_c  (done_idx),
        .done_eol_c  (done_eol)
    );

    // State, sequencing and beat counter registers; outputs registered from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_PAUSED;
            resume        <= 1'b0;
            song          <= '0;
            beat_cnt      <= '0;
            play          <= 1'b0;
            reset_player  <= 1'b0;
            playlist_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            resume        <= resume_nxt;
            song          <= song_nxt;
            beat_cnt      <= beat_cnt_nxt;
            play          <= (state_nxt == ST_PLAYING);
            reset_player  <= (state_nxt == ST_ADVANCE);
            playlist_done <= done_nxt;
        end
    end

    // Next state: next > prev > song_done > play_button; losers are dropped
    always_comb begin
        state_nxt    = state;
        resume_nxt   = resume;
        song_nxt     = song;
        done_nxt     = 1'b0;
        beat_cnt_nxt = beat_cnt;

        case (state)
            ST_PAUSED: begin
                if (next_button) begin
                    state_nxt  = ST_ADVANCE;
                    resume_nxt = 1'b0;
                    song_nxt   = next_idx;
                end else if (prev_button) begin
                    state_nxt  = ST_ADVANCE;
                    resume_nxt = 1'b0;
                    song_nxt   = prev_idx;
                end else if (play_button) begin
                    state_nxt  = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (beat && (beat_cnt != '1)) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
                if (next_button) begin
                    state_nxt  = ST_ADVANCE;
                    resume_nxt = 1'b1;
                    song_nxt   = next_idx;
                end else if (prev_button) begin
                    state_nxt  = ST_ADVANCE;
                    resume_nxt = 1'b1;
                    song_nxt   = prev_idx;
                end else if (song_done) begin
                    state_nxt  = ST_ADVANCE;
                    resume_nxt = ~done_eol;
                    song_nxt   = done_idx;
                    done_nxt   = done_eol;
                end else if (play_button) begin
                    state_nxt  = ST_PAUSED;
                end
            end
            ST_ADVANCE: begin
                beat_cnt_nxt = '0;
                state_nxt    = resume ? ST_PLAYING : ST_PAUSED;
            end
            default: begin
                state_nxt = ST_PAUSED;
            end
        endcase
    end

endmodule

// File: tb/tb_playlist_mcu.sv
// Directed testbench for playlist_mcu.
module tb_playlist_mcu;

    logic       clk;
    logic       reset;
    logic       play_button, next_button, prev_button;
    logic [1:0] repeat_mode;
    logic       beat, song_done;
    logic       play, reset_player, playlist_done;
    logic [1:0] song;

    int n_cmp;
    int n_bad;

    playlist_mcu #(
        .NUM_SONGS   (4),
        .SONG_W      (2),
        .PREV_WINDOW (96),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .play_button   (play_button),
        .next_button   (next_button),
        .prev_button   (prev_button),
        .repeat_mode   (repeat_mode),
        .beat          (beat),
        .song_done     (song_done),
        .play          (play),
        .reset_player  (reset_player),
        .song          (song),
        .playlist_done (playlist_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 play, 1 next, 2 prev, 3 song_done, 4 beat
    task automatic press(input int which);
        case (which)
            0: play_button = 1'b1;
            1: next_button = 1'b1;
            2: prev_button = 1'b1;
            3: song_done   = 1'b1;
            default: beat  = 1'b1;
        endcase
        tick();
        play_button = 1'b0;
        next_button = 1'b0;
        prev_button = 1'b0;
        song_done   = 1'b0;
        beat        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Reset, step to song n while paused, then start playing
    task automatic goto_playing(input int n, input logic [1:0] mode);
        repeat_mode = mode;
        do_reset();
        for (int i = 0; i < n; i++) begin
            press(1);
            tick();
        end
        press(0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) press(4);
    endtask

    task automatic test_reset();
        int rp_seen;
        do_reset();
        n_cmp++; if ({play, reset_player, song, playlist_done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_outputs got=%b exp=00000", {play, reset_player, song, playlist_done});
        end
        press(0);
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL play_after_button got=%b exp=1", play); end
        n_cmp++; if (song !== 2'd0) begin n_bad++; $display("FAIL song_after_play got=%0d exp=0", song); end
        rp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (reset_player === 1'b1) rp_seen++;
            tick();
        end
        n_cmp++; if (rp_seen !== 0) begin n_bad++; $display("FAIL rp_on_play got=%0d exp=0", rp_seen); end
        press(0);
        n_cmp++; if (play !== 1'b0) begin n_bad++; $display("FAIL pause_toggle got=%b exp=0", play); end
    endtask

    task automatic test_next_wrap();
        goto_playing(3, 2'b00);
        n_cmp++; if (song !== 2'd3 || play !== 1'b1) begin
            n_bad++; $display("FAIL setup_song3 got song=%0d play=%b exp song=3 play=1", song, play);
        end
        press(1);
        n_cmp++; if ({song, reset_player, play} !== {2'd0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL next_wrap_adv got song=%0d rp=%b play=%b exp 0 1 0", song, reset_player, play);
        end
        tick();
        n_cmp++; if ({song, reset_player, play} !== {2'd0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL next_wrap_resume got song=%0d rp=%b play=%b exp 0 0 1", song, reset_player, play);
        end
    endtask

    task automatic test_prev();
        goto_playing(2, 2'b00);
        beats(10);
        press(2);
        n_cmp++; if (song !== 2'd1 || reset_player !== 1'b1) begin
            n_bad++; $display("FAIL prev_in_window got song=%0d rp=%b exp 1 1", song, reset_player);
        end
        tick();
        press(1);
        tick();
        beats(100);
        press(2);
        n_cmp++; if (song !== 2'd2 || reset_player !== 1'b1) begin
            n_bad++; $display("FAIL prev_restart got song=%0d rp=%b exp 2 1", song, reset_player);
        end
        tick();
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL prev_restart_play got=%b exp=1", play); end
        // beat count was cleared by the restart, so prev now steps back
        press(2);
        n_cmp++; if (song !== 2'd1) begin n_bad++; $display("FAIL prev_after_clear got=%0d exp=1", song); end
        tick();
        goto_playing(0, 2'b00);
        press(2);
        n_cmp++; if (song !== 2'd3) begin n_bad++; $display("FAIL prev_wrap got=%0d exp=3", song); end
        tick();
        goto_playing(1, 2'b00);
        beats(95);
        press(2);
        n_cmp++; if (song !== 2'd0) begin n_bad++; $display("FAIL prev_beat95 got=%0d exp=0", song); end
        tick();
        goto_playing(1, 2'b00);
        beats(96);
        press(2);
        n_cmp++; if (song !== 2'd1) begin n_bad++; $display("FAIL prev_beat96 got=%0d exp=1", song); end
        tick();
    endtask

    task automatic test_song_done();
        goto_playing(3, 2'b00);
        press(3);
        n_cmp++; if ({song, playlist_done, reset_player} !== {2'd0, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL done_off_last got song=%0d pd=%b rp=%b exp 0 1 1", song, playlist_done, reset_player);
        end
        tick();
        n_cmp++; if (playlist_done !== 1'b0 || play !== 1'b0) begin
            n_bad++; $display("FAIL done_off_after got pd=%b play=%b exp 0 0", playlist_done, play);
        end
        tick();
        n_cmp++; if (play !== 1'b0) begin n_bad++; $display("FAIL done_off_paused got=%b exp=0", play); end

        goto_playing(3, 2'b01);
        press(3);
        n_cmp++; if (song !== 2'd0 || playlist_done !== 1'b0) begin
            n_bad++; $display("FAIL done_all got song=%0d pd=%b exp 0 0", song, playlist_done);
        end
        tick();
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL done_all_play got=%b exp=1", play); end

        goto_playing(3, 2'b10);
        press(3);
        n_cmp++; if (song !== 2'd3 || playlist_done !== 1'b0 || reset_player !== 1'b1) begin
            n_bad++; $display("FAIL done_one got song=%0d pd=%b rp=%b exp 3 0 1", song, playlist_done, reset_player);
        end
        tick();
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL done_one_play got=%b exp=1", play); end

        goto_playing(3, 2'b11);
        press(3);
        n_cmp++; if (song !== 2'd0 || playlist_done !== 1'b1) begin
            n_bad++; $display("FAIL done_mode11 got song=%0d pd=%b exp 0 1", song, playlist_done);
        end
        tick();
        n_cmp++; if (play !== 1'b0) begin n_bad++; $display("FAIL done_mode11_paused got=%b exp=0", play); end

        goto_playing(1, 2'b00);
        press(3);
        n_cmp++; if (song !== 2'd2 || playlist_done !== 1'b0) begin
            n_bad++; $display("FAIL done_off_mid got song=%0d pd=%b exp 2 0", song, playlist_done);
        end
        tick();
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL done_off_mid_play got=%b exp=1", play); end
    endtask

    task automatic test_back_to_back();
        goto_playing(1, 2'b01);
        next_button = 1'b1;
        song_done   = 1'b1;
        press(1);
        n_cmp++; if (song !== 2'd2 || reset_player !== 1'b1) begin
            n_bad++; $display("FAIL next_and_done got song=%0d rp=%b exp 2 1", song, reset_player);
        end
        press(0);
        n_cmp++; if (play !== 1'b1 || song !== 2'd2 || reset_player !== 1'b0) begin
            n_bad++; $display("FAIL play_in_advance got play=%b song=%0d rp=%b exp 1 2 0", play, song, reset_player);
        end
        tick();
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL play_in_advance_hold got=%b exp=1", play); end
        next_button = 1'b1;
        press(2);
        n_cmp++; if (song !== 2'd3) begin n_bad++; $display("FAIL next_over_prev got=%0d exp=3", song); end
        tick();
    endtask

    task automatic test_async_reset();
        goto_playing(2, 2'b00);
        press(1);
        n_cmp++; if (reset_player !== 1'b1 || song !== 2'd3) begin
            n_bad++; $display("FAIL pre_reset_adv got rp=%b song=%0d exp 1 3", reset_player, song);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({play, reset_player, song, playlist_done} !== 5'b0) begin
            n_bad++; $display("FAIL async_reset got=%b exp=00000", {play, reset_player, song, playlist_done});
        end
        tick();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (song !== 2'd0 || play !== 1'b0 || reset_player !== 1'b0) begin
            n_bad++; $display("FAIL post_reset got song=%0d play=%b rp=%b exp 0 0 0", song, play, reset_player);
        end
        press(0);
        n_cmp++; if (play !== 1'b1) begin n_bad++; $display("FAIL post_reset_paused got=%b exp=1", play); end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        play_button = 1'b0;
        next_button = 1'b0;
        prev_button = 1'b0;
        song_done   = 1'b0;
        beat        = 1'b0;
        repeat_mode = 2'b00;
        test_reset();
        test_next_wrap();
        test_prev();
        test_song_done();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
